// File: rtl/ioctl_upload_reader_pkg.sv
// ioctl_upload_pkg: shared FSM states and constants for the ioctl upload reader.
package ioctl_upload_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_e;
    localparam logic [7:0] FILL_DEFAULT = 8'hFF;
    localparam int IOCTL_AW = 25;
endpackage

// File: rtl/ioctl_upload_reader_if.sv
// ioctl_upload_reader_if: HPS ioctl upload bus; master is the host side, slave is the reader.
interface ioctl_upload_reader_if;
    import ioctl_upload_pkg::*;
    logic                ioctl_upload;
    logic                ioctl_rd;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_din;
    logic                ioctl_wait;
    modport master (output ioctl_upload, ioctl_rd, ioctl_addr, input ioctl_din, ioctl_wait);
    modport slave (input ioctl_upload, ioctl_rd, ioctl_addr, output ioctl_din, ioctl_wait);
endinterface

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves host upload reads from a synchronous memory, stalling with ioctl_wait.
// Optional running checksum output enabled by defining IOCTL_UPLOAD_CSUM_EN.
module ioctl_upload_reader
    import ioctl_upload_pkg::*;
#(
    parameter int         ADDR_W = 15,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] FILL   = FILL_DEFAULT
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    ioctl_upload_reader_if.slave   ioctl,
    input  logic [ADDR_W:0]        size,
    output logic [ADDR_W-1:0]      mem_a,
    output logic                   mem_rd,
    input  logic [7:0]             mem_q,
    output logic                   busy,
    output logic [ADDR_W:0]        bytes_sent,
`ifdef IOCTL_UPLOAD_CSUM_EN
    output logic [7:0]             checksum,
`endif
    output logic                   upload_done
);
    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                oor_q, oor_d;
    logic [7:0]          din_q, din_d;
    logic                wait_q, wait_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic                mem_rd_q, mem_rd_d;
    logic                up_q, done_q;
    logic [ADDR_W:0]     sent_q, sent_d;
    logic                rise, in_range;
`ifdef IOCTL_UPLOAD_CSUM_EN
    logic [7:0]          csum_q, csum_d;
    assign checksum = csum_q;
`endif

    assign rise     = ioctl.ioctl_upload & ~up_q;
    assign in_range = (ioctl.ioctl_addr[IOCTL_AW-1:ADDR_W] == '0) &&
                      ({1'b0, ioctl.ioctl_addr[ADDR_W-1:0]} < size);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        oor_d    = oor_q;
        din_d    = din_q;
        wait_d   = wait_q;
        mem_a_d  = mem_a_q;
        mem_rd_d = 1'b0;
        sent_d   = rise ? '0 : sent_q;
`ifdef IOCTL_UPLOAD_CSUM_EN
        csum_d   = rise ? 8'h00 : csum_q;
`endif
        // Dropping the session aborts any fetch but keeps the counters
        if (!ioctl.ioctl_upload) begin
            state_d = IDLE;
            wait_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ioctl.ioctl_rd) begin
                    wait_d  = 1'b1;
                    oor_d   = !in_range;
                    state_d = in_range ? FETCH : PRESENT;
                    if (in_range) begin
                        mem_a_d  = ioctl.ioctl_addr[ADDR_W-1:0];
                        mem_rd_d = 1'b1;
                        cnt_d    = 2'(RD_LAT);
                    end
                end
                FETCH: begin
                    cnt_d   = cnt_q - 2'd1;
                    state_d = (cnt_d == 2'd0) ? PRESENT : FETCH;
                end
                PRESENT: begin
                    din_d   = oor_q ? FILL : mem_q;
                    wait_d  = 1'b0;
                    sent_d  = sent_q[ADDR_W] ? sent_q : sent_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IOCTL_UPLOAD_CSUM_EN
                    csum_d  = csum_q + din_d;
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            oor_q    <= 1'b0;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            mem_a_q  <= '0;
            mem_rd_q <= 1'b0;
            up_q     <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
`ifdef IOCTL_UPLOAD_CSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oor_q    <= oor_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            mem_a_q  <= mem_a_d;
            mem_rd_q <= mem_rd_d;
            up_q     <= ioctl.ioctl_upload;
            done_q   <= up_q & ~ioctl.ioctl_upload;
            sent_q   <= sent_d;
`ifdef IOCTL_UPLOAD_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = wait_q;
    assign mem_a            = mem_a_q;
    assign mem_rd           = mem_rd_q;
    assign busy             = up_q;
    assign bytes_sent       = sent_q;
    assign upload_done      = done_q;
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: directed bench with one RD_LAT=1 and one RD_LAT=3 reader instance.
module tb_ioctl_upload_reader;
  import ioctl_upload_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n;
  logic [15:0] size;
  int          tests = 0;
  int          fails = 0;
  ioctl_upload_reader_if if1();
  ioctl_upload_reader_if if3();
  logic [14:0] ma1, ma3;
  logic        mr1, mr3, busy1, busy3, done1, done3;
  logic [7:0]  mq1, mq3, p0, p1;
  logic [15:0] bs1, bs3;
`ifdef IOCTL_UPLOAD_CSUM_EN
  logic [7:0]  cs1, cs3;
`endif
  ioctl_upload_reader #(.ADDR_W(15), .RD_LAT(1)) u1 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl(if1), .size(size),
    .mem_a(ma1), .mem_rd(mr1), .mem_q(mq1), .busy(busy1), .bytes_sent(bs1),
`ifdef IOCTL_UPLOAD_CSUM_EN
    .checksum(cs1),
`endif
    .upload_done(done1));
  ioctl_upload_reader #(.ADDR_W(15), .RD_LAT(3)) u3 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl(if3), .size(size),
    .mem_a(ma3), .mem_rd(mr3), .mem_q(mq3), .busy(busy3), .bytes_sent(bs3),
`ifdef IOCTL_UPLOAD_CSUM_EN
    .checksum(cs3),
`endif
    .upload_done(done3));
  logic [7:0] mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int nrd1 = 0, nrd3 = 0;
  always @(posedge clk) begin
    mq1 <= mr1 ? mem[ma1[1:0]] : 8'hEE;
    p0  <= mr3 ? mem[ma3[1:0]] : 8'hEE;
    p1  <= p0;
    mq3 <= p1;
    if (mr3 === 1'b1) nrd3 <= nrd3 + 1;
    if (mr1 === 1'b1) nrd1 <= nrd1 + 1;
  end
  logic        sel;
  logic        w_m, mr_m;
  logic [7:0]  din_m;
  logic [14:0] ma_m;
  int          nrd_m;
  assign w_m   = sel ? if3.ioctl_wait : if1.ioctl_wait;
  assign mr_m  = sel ? mr3 : mr1;
  assign din_m = sel ? if3.ioctl_din : if1.ioctl_din;
  assign ma_m  = sel ? ma3 : ma1;
  assign nrd_m = sel ? nrd3 : nrd1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rd_req(input logic [24:0] a, input logic [7:0] exp, input int n);
    int base;
    base = nrd_m;
    if (sel) begin if3.ioctl_rd = 1'b1; if3.ioctl_addr = a; end
    else begin if1.ioctl_rd = 1'b1; if1.ioctl_addr = a; end
    @(negedge clk);
    if (sel) if3.ioctl_rd = 1'b0; else if1.ioctl_rd = 1'b0;
    chk("wait_rise", w_m, 1'b1);
    if (n > 2) begin
      chk("mem_rd", mr_m, 1'b1);
      chk("mem_a", ma_m, a[14:0]);
    end else begin
      chk("no_mem_rd", mr_m, 1'b0);
    end
    for (int k = 2; k < n; k++) begin
      @(negedge clk);
      chk("wait_hold", w_m, 1'b1);
    end
    @(negedge clk);
    chk("wait_fall", w_m, 1'b0);
    chk("din", din_m, exp);
    chk("rd_pulses", nrd_m - base, (n > 2) ? 1 : 0);
  endtask
  initial begin
    sel = 1'b0;
    reset_n = 1'b0;
    size = 16'd4;
    if1.ioctl_upload = 1'b0; if1.ioctl_rd = 1'b0; if1.ioctl_addr = '0;
    if3.ioctl_upload = 1'b0; if3.ioctl_rd = 1'b0; if3.ioctl_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_din", if1.ioctl_din, 8'h00);
    chk("rst_wait", if1.ioctl_wait, 1'b0);
    chk("rst_mem_a", ma1, 15'd0);
    chk("rst_mem_rd", mr1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_bytes", bs1, 16'd0);
    chk("rst_done", done1, 1'b0);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("rst_csum", cs1, 8'h00);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    if1.ioctl_upload = 1'b1;
    @(negedge clk);
    chk("busy_on", busy1, 1'b1);
    rd_req(25'd0, 8'h11, 3);
    rd_req(25'd1, 8'h22, 3);
    rd_req(25'd2, 8'h33, 3);
    rd_req(25'd3, 8'h44, 3);
    chk("bytes_4", bs1, 16'd4);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("csum_aa", cs1, 8'hAA);
`endif
    rd_req(25'd4, 8'hFF, 2);
    chk("bytes_5", bs1, 16'd5);
    rd_req(25'h10000, 8'hFF, 2);
    chk("bytes_6", bs1, 16'd6);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("csum_a8", cs1, 8'hA8);
`endif
    begin
      int base;
      base = nrd1;
      if1.ioctl_rd = 1'b1; if1.ioctl_addr = 25'd1;
      @(negedge clk);
      if1.ioctl_addr = 25'd2;
      @(negedge clk);
      if1.ioctl_rd = 1'b0;
      chk("ign_wait", if1.ioctl_wait, 1'b1);
      @(negedge clk);
      chk("ign_din", if1.ioctl_din, 8'h22);
      chk("ign_wait_fall", if1.ioctl_wait, 1'b0);
      @(negedge clk);
      chk("ign_no_restart", if1.ioctl_wait, 1'b0);
      chk("ign_bytes", bs1, 16'd7);
      chk("ign_rd_pulses", nrd1 - base, 1);
    end
    if1.ioctl_upload = 1'b0;
    @(negedge clk);
    chk("done_pulse", done1, 1'b1);
    chk("busy_off", busy1, 1'b0);
    chk("done_bytes", bs1, 16'd7);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("done_csum", cs1, 8'hCA);
`endif
    @(negedge clk);
    chk("done_once", done1, 1'b0);
    if1.ioctl_upload = 1'b1;
    rd_req(25'd3, 8'h44, 3);
    chk("rise_rd_bytes", bs1, 16'd1);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("rise_rd_csum", cs1, 8'h44);
`endif
    sel = 1'b1;
    if3.ioctl_upload = 1'b1;
    @(negedge clk);
    rd_req(25'd2, 8'h33, 5);
    chk("l3_bytes", bs3, 16'd1);
    if3.ioctl_rd = 1'b1; if3.ioctl_addr = 25'd0;
    @(negedge clk);
    if3.ioctl_rd = 1'b0;
    chk("abort_wait_pre", if3.ioctl_wait, 1'b1);
    if3.ioctl_upload = 1'b0;
    @(negedge clk);
    chk("abort_wait", if3.ioctl_wait, 1'b0);
    chk("abort_done", done3, 1'b1);
    chk("abort_bytes", bs3, 16'd1);
    @(negedge clk);
    chk("abort_done_once", done3, 1'b0);
    chk("abort_idle", if3.ioctl_wait, 1'b0);
    if3.ioctl_upload = 1'b1;
    @(negedge clk);
    rd_req(25'd1, 8'h22, 5);
    chk("l3_bytes_new", bs3, 16'd1);
    if3.ioctl_rd = 1'b1; if3.ioctl_addr = 25'd3;
    @(negedge clk);
    if3.ioctl_rd = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wait", if3.ioctl_wait, 1'b0);
    chk("arst_din", if3.ioctl_din, 8'h00);
    chk("arst_mem_a", ma3, 15'd0);
    chk("arst_mem_rd", mr3, 1'b0);
    chk("arst_busy", busy3, 1'b0);
    chk("arst_bytes", bs3, 16'd0);
    chk("arst_done", done3, 1'b0);
`ifdef IOCTL_UPLOAD_CSUM_EN
    chk("arst_csum", cs3, 8'h00);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy3, 1'b1);
    rd_req(25'd3, 8'h44, 5);
    chk("post_rst_bytes", bs3, 16'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
